// File: rtl/lw_hash_arbiter_if.sv
// Requester-side and engine-side signal bundle for lw_hash_arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface lw_hash_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int WORD  = 64
);
    logic [N_REQ-1:0]      req_i;
    logic [4*N_REQ-1:0]    req_opcode_i;
    logic [WORD*N_REQ-1:0] req_data_i;
    logic [N_REQ-1:0]      req_data_valid_i;
    logic [N_REQ-1:0]      req_last_i;
    logic [WORD*N_REQ-1:0] req_key_i;
    logic [N_REQ-1:0]      req_key_valid_i;
    logic [N_REQ-1:0]      req_new_key_i;
    logic [N_REQ-1:0]      req_abort_i;
    logic [N_REQ-1:0]      gnt_o;
    logic [N_REQ-1:0]      req_ready_o;
    logic [N_REQ-1:0]      req_key_ready_o;
    logic [N_REQ-1:0]      req_done_o;
    logic                  timeout_o;
    logic [8*WORD-1:0]     hash_o;
    logic                  eng_start_o;
    logic                  eng_abort_o;
    logic                  eng_last_o;
    logic                  eng_data_valid_o;
    logic                  eng_key_valid_o;
    logic                  eng_new_key_o;
    logic [WORD-1:0]       eng_data_o;
    logic [WORD-1:0]       eng_key_o;
    logic [3:0]            eng_opcode_o;
    logic                  eng_ready_i;
    logic                  eng_key_ready_i;
    logic                  eng_core_ready_i;
    logic                  eng_done_i;
    logic [8*WORD-1:0]     eng_hash_i;

    modport slave (
        input  req_i, req_opcode_i, req_data_i, req_data_valid_i, req_last_i,
        input  req_key_i, req_key_valid_i, req_new_key_i, req_abort_i,
        input  eng_ready_i, eng_key_ready_i, eng_core_ready_i, eng_done_i, eng_hash_i,
        output gnt_o, req_ready_o, req_key_ready_o, req_done_o, timeout_o, hash_o,
        output eng_start_o, eng_abort_o, eng_last_o, eng_data_valid_o, eng_key_valid_o,
        output eng_new_key_o, eng_data_o, eng_key_o, eng_opcode_o
    );

    modport master (
        output req_i, req_opcode_i, req_data_i, req_data_valid_i, req_last_i,
        output req_key_i, req_key_valid_i, req_new_key_i, req_abort_i,
        output eng_ready_i, eng_key_ready_i, eng_core_ready_i, eng_done_i, eng_hash_i,
        input  gnt_o, req_ready_o, req_key_ready_o, req_done_o, timeout_o, hash_o,
        input  eng_start_o, eng_abort_o, eng_last_o, eng_data_valid_o, eng_key_valid_o,
        input  eng_new_key_o, eng_data_o, eng_key_o, eng_opcode_o
    );
endinterface

// File: rtl/lw_hash_arbiter.sv
// Round-robin arbiter sharing one lw_hmac engine between N_REQ requesters, with
// per-requester HMAC key ownership tracking and a stall watchdog.
module lw_hash_arbiter #(
    parameter int N_REQ   = 2,
    parameter int WORD    = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             aresetn_i,
    lw_hash_arbiter_if.slave bus
);
    localparam int              IDXW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int              WDW       = $clog2(TIMEOUT + 1);
    localparam logic [IDXW-1:0] LAST_RST  = IDXW'(N_REQ - 1);
    localparam logic [IDXW:0]   N_W       = (IDXW + 1)'(N_REQ);
    localparam logic [WDW-1:0]  TIMEOUT_W = WDW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RELEASE} state_t;

    state_t              state_reg, state_next;
    logic [IDXW-1:0]     g_reg, g_next;
    logic [IDXW-1:0]     last_gnt_reg, last_gnt_next;
    logic [IDXW-1:0]     owner_reg, owner_next;
    logic                owner_vld_reg, owner_vld_next;
    logic [WDW-1:0]      wdog_reg, wdog_next;
    logic [N_REQ-1:0]    gnt_reg, gnt_next;
    logic [N_REQ-1:0]    done_reg, done_next;
    logic [8*WORD-1:0]   hash_reg, hash_next;
    logic [3:0]          opcode_reg, opcode_next;
    logic                force_key_reg, force_key_next;

    logic [WORD-1:0]     data_arr [N_REQ];
    logic [WORD-1:0]     key_arr  [N_REQ];
    logic [3:0]          op_arr   [N_REQ];
    logic [N_REQ-1:0]    g_onehot, pick_onehot;
    logic [IDXW-1:0]     pick_idx;
    logic [IDXW:0]       cand;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign data_arr[gi]    = bus.req_data_i[gi*WORD +: WORD];
        assign key_arr[gi]     = bus.req_key_i[gi*WORD +: WORD];
        assign op_arr[gi]      = bus.req_opcode_i[gi*4 +: 4];
        assign g_onehot[gi]    = (g_reg == IDXW'(gi));
        assign pick_onehot[gi] = (pick_idx == IDXW'(gi));
    end

    // Scan offsets from farthest to nearest so the nearest requester after last_gnt wins.
    always_comb begin
        pick_idx = last_gnt_reg;
        cand     = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = {1'b0, last_gnt_reg} + (IDXW + 1)'(k);
            if (cand >= N_W) cand = cand - N_W;
            if (bus.req_i[cand[IDXW-1:0]]) pick_idx = cand[IDXW-1:0];
        end
    end

    logic in_launch, in_busy, active;
    logic sel_dv, sel_last, sel_kv, sel_new_key, sel_abort;
    logic [3:0] sel_op;
    logic done_hit, wd_fire, abort_hit, new_key_launch, handshake;

    assign in_launch      = (state_reg == LAUNCH);
    assign in_busy        = (state_reg == BUSY);
    assign active         = in_launch | in_busy;
    assign sel_dv         = bus.req_data_valid_i[g_reg];
    assign sel_last       = bus.req_last_i[g_reg];
    assign sel_kv         = bus.req_key_valid_i[g_reg];
    assign sel_new_key    = bus.req_new_key_i[g_reg];
    assign sel_abort      = bus.req_abort_i[g_reg];
    assign sel_op         = op_arr[g_reg];
    assign done_hit       = in_busy & bus.eng_done_i;
    assign wd_fire        = in_busy & (wdog_reg == TIMEOUT_W);
    assign abort_hit      = active & ~done_hit & (sel_abort | wd_fire);
    assign new_key_launch = sel_new_key | ~owner_vld_reg | (owner_reg != g_reg);
    assign handshake      = (sel_dv & bus.eng_ready_i) | (sel_kv & bus.eng_key_ready_i);

    assign bus.eng_start_o      = in_launch;
    assign bus.eng_abort_o      = abort_hit;
    assign bus.timeout_o        = wd_fire & ~done_hit;
    assign bus.eng_opcode_o     = in_launch ? sel_op : (in_busy ? opcode_reg : 4'h0);
    assign bus.eng_data_o       = active ? data_arr[g_reg] : '0;
    assign bus.eng_data_valid_o = active & sel_dv;
    assign bus.eng_last_o       = active & sel_last;
    assign bus.eng_key_o        = in_busy ? key_arr[g_reg] : '0;
    assign bus.eng_key_valid_o  = in_busy & sel_kv;
    // A key cached for another requester must never be reused, so force a reload.
    assign bus.eng_new_key_o    = in_launch ? new_key_launch
                                            : (in_busy & (sel_new_key | force_key_reg));
    assign bus.req_ready_o      = g_onehot & {N_REQ{in_launch ? sel_dv : (in_busy & bus.eng_ready_i)}};
    assign bus.req_key_ready_o  = g_onehot & {N_REQ{in_busy & bus.eng_key_ready_i}};
    assign bus.gnt_o            = gnt_reg;
    assign bus.req_done_o       = done_reg;
    assign bus.hash_o           = hash_reg;

    always_comb begin
        state_next     = state_reg;
        g_next         = g_reg;
        last_gnt_next  = last_gnt_reg;
        owner_next     = owner_reg;
        owner_vld_next = owner_vld_reg;
        wdog_next      = wdog_reg;
        gnt_next       = gnt_reg;
        done_next      = '0;
        hash_next      = hash_reg;
        opcode_next    = opcode_reg;
        force_key_next = force_key_reg;
        case (state_reg)
            IDLE: begin
                if (bus.eng_core_ready_i && (|bus.req_i)) begin
                    g_next     = pick_idx;
                    gnt_next   = pick_onehot;
                    hash_next  = '0;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                if (abort_hit) begin
                    gnt_next   = '0;
                    state_next = RELEASE;
                    if (sel_op[3]) owner_vld_next = 1'b0;
                end else if (sel_dv) begin
                    wdog_next      = '0;
                    opcode_next    = sel_op;
                    force_key_next = new_key_launch;
                    state_next     = BUSY;
                    if (sel_op[3]) begin
                        owner_next     = g_reg;
                        owner_vld_next = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (done_hit) begin
                    hash_next  = bus.eng_hash_i;
                    done_next  = g_onehot;
                    gnt_next   = '0;
                    state_next = RELEASE;
                end else if (abort_hit) begin
                    gnt_next   = '0;
                    state_next = RELEASE;
                    if (opcode_reg[3]) owner_vld_next = 1'b0;
                end else begin
                    wdog_next = handshake ? '0 : wdog_reg + 1'b1;
                end
            end
            RELEASE: begin
                if (bus.eng_core_ready_i) begin
                    last_gnt_next = g_reg;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_reg     <= IDLE;
            g_reg         <= '0;
            last_gnt_reg  <= LAST_RST;
            owner_reg     <= '0;
            owner_vld_reg <= 1'b0;
            wdog_reg      <= '0;
            gnt_reg       <= '0;
            done_reg      <= '0;
            hash_reg      <= '0;
            opcode_reg    <= 4'h0;
            force_key_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            g_reg         <= g_next;
            last_gnt_reg  <= last_gnt_next;
            owner_reg     <= owner_next;
            owner_vld_reg <= owner_vld_next;
            wdog_reg      <= wdog_next;
            gnt_reg       <= gnt_next;
            done_reg      <= done_next;
            hash_reg      <= hash_next;
            opcode_reg    <= opcode_next;
            force_key_reg <= force_key_next;
        end
    end
endmodule

// File: tb/tb_lw_hash_arbiter.sv
// Directed bench for lw_hash_arbiter: the engine side is driven by hand and every
// expected value below is worked out from the arbitration and ownership rules.
module tb_lw_hash_arbiter;
    localparam int N  = 2;
    localparam int W  = 64;
    localparam int TO = 16;
    localparam logic [W-1:0] ABC = 64'h0000_0000_0061_6263;

    logic clk = 1'b0;
    logic aresetn;
    always #5 clk = ~clk;

    lw_hash_arbiter_if #(.N_REQ(N), .WORD(W)) bus ();

    lw_hash_arbiter #(.N_REQ(N), .WORD(W), .TIMEOUT(TO)) dut (
        .clk_i     (clk),
        .aresetn_i (aresetn),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1 << i);
    endfunction

    // IDLE -> LAUNCH -> BUSY for requester idx; returns in the first BUSY cycle.
    task automatic launch(input int idx, input logic [3:0] op, input logic nk, input logic exp_nk);
        bus.req_i[idx]               = 1'b1;
        bus.req_opcode_i[idx*4 +: 4] = op;
        bus.req_data_i[idx*W +: W]   = ABC;
        bus.req_data_valid_i[idx]    = 1'b1;
        bus.req_last_i[idx]          = 1'b1;
        bus.req_new_key_i[idx]       = nk;
        #1;
        check_eq("gnt_before", bus.gnt_o, '0);
        tick();
        check_eq("gnt", bus.gnt_o, oh(idx));
        check_eq("start", bus.eng_start_o, 1'b1);
        check_eq("launch_opcode", bus.eng_opcode_o, op);
        check_eq("launch_data", bus.eng_data_o, ABC);
        check_eq("launch_ready", bus.req_ready_o, oh(idx));
        check_eq("new_key", bus.eng_new_key_o, exp_nk);
        bus.req_i[idx] = 1'b0;
        tick();
        bus.req_data_valid_i[idx] = 1'b0;
        bus.req_last_i[idx]       = 1'b0;
        #1;
        check_eq("busy_start", bus.eng_start_o, 1'b0);
        check_eq("busy_opcode", bus.eng_opcode_o, op);
        $display("job: req%0d opcode %h granted, new_key=%0b", idx, op, bus.eng_new_key_o);
    endtask

    task automatic finish_done(input int idx, input logic [511:0] h);
        bus.eng_hash_i = h;
        bus.eng_done_i = 1'b1;
        #1;
        check_eq("done_early", bus.req_done_o, '0);
        tick();
        bus.eng_done_i = 1'b0;
        #1;
        check_eq("done", bus.req_done_o, oh(idx));
        check_eq("hash", bus.hash_o, h);
        check_eq("gnt_release", bus.gnt_o, '0);
        tick();
        check_eq("done_pulse", bus.req_done_o, '0);
        check_eq("hash_hold", bus.hash_o, h);
        $display("job: req%0d done, hash %0h", idx, h[63:0]);
    endtask

    initial begin
        #100000;
        $display("FAIL guard: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic early;
        bus.req_i = '0;            bus.req_opcode_i = '0;     bus.req_data_i = '0;
        bus.req_data_valid_i = '0; bus.req_last_i = '0;       bus.req_key_i = '0;
        bus.req_key_valid_i = '0;  bus.req_new_key_i = '0;    bus.req_abort_i = '0;
        bus.eng_ready_i = 1'b0;    bus.eng_key_ready_i = 1'b0; bus.eng_core_ready_i = 1'b1;
        bus.eng_done_i = 1'b0;     bus.eng_hash_i = '0;
        aresetn = 1'b0;
        tick(); tick();
        check_eq("rst_gnt", bus.gnt_o, '0);
        check_eq("rst_done", bus.req_done_o, '0);
        check_eq("rst_hash", bus.hash_o, '0);
        check_eq("rst_start", bus.eng_start_o, 1'b0);
        check_eq("rst_abort", bus.eng_abort_o, 1'b0);
        check_eq("rst_timeout", bus.timeout_o, 1'b0);
        aresetn = 1'b1;
        tick();

        // Single SHA job "abc" on requester 0
        launch(0, 4'h0, 1'b0, 1'b1);
        finish_done(0, {8{64'hBA78_16BF_8F01_CFEA}});

        // Reset asserted mid-job clears the grant immediately
        launch(1, 4'h0, 1'b0, 1'b1);
        #2 aresetn = 1'b0;
        #1;
        check_eq("rst_mid_gnt", bus.gnt_o, '0);
        check_eq("rst_mid_hash", bus.hash_o, '0);
        tick();
        aresetn = 1'b1;
        tick();

        // Contention: both requesters always asking -> 0,1,0,1
        bus.req_i = 2'b11; bus.req_data_valid_i = 2'b11; bus.req_last_i = 2'b11;
        bus.req_opcode_i = '0; bus.req_new_key_i = '0;
        for (int j = 0; j < 4; j++) begin
            int e;
            e = j % 2;
            tick();
            check_eq("rr_gnt", bus.gnt_o, oh(e));
            check_eq("rr_onehot", $countones(bus.gnt_o), 1);
            bus.req_i[e] = 1'b0;
            tick();
            bus.eng_hash_i = {8{64'(j + 1)}};
            bus.eng_done_i = 1'b1;
            tick();
            bus.eng_done_i = 1'b0;
            #1;
            check_eq("rr_done", bus.req_done_o, oh(e));
            $display("job: contention round %0d granted req%0d", j, e);
            bus.req_i[e] = 1'b1;
            tick();
        end
        bus.req_i = '0; bus.req_data_valid_i = '0; bus.req_last_i = '0;
        tick();

        // Key ownership
        launch(0, 4'h8, 1'b0, 1'b1);
        finish_done(0, {8{64'h1111}});
        launch(0, 4'h8, 1'b0, 1'b0);
        finish_done(0, {8{64'h2222}});
        launch(1, 4'h8, 1'b0, 1'b1);
        finish_done(1, {8{64'h3333}});

        // Abort of an HMAC job by its owner; foreign abort ignored
        launch(0, 4'h8, 1'b0, 1'b1);
        bus.req_abort_i = 2'b10;
        #1;
        check_eq("abort_foreign", bus.eng_abort_o, 1'b0);
        bus.req_abort_i = 2'b01;
        #1;
        check_eq("abort", bus.eng_abort_o, 1'b1);
        check_eq("abort_no_timeout", bus.timeout_o, 1'b0);
        tick();
        bus.req_abort_i = '0;
        bus.eng_core_ready_i = 1'b0;
        #1;
        check_eq("abort_pulse", bus.eng_abort_o, 1'b0);
        check_eq("abort_no_done", bus.req_done_o, '0);
        check_eq("abort_gnt", bus.gnt_o, '0);
        tick();
        bus.eng_core_ready_i = 1'b1;
        tick();
        $display("job: req0 aborted");
        launch(0, 4'h8, 1'b0, 1'b1);
        finish_done(0, {8{64'h4444}});

        // Watchdog: data stops after the first beat
        launch(0, 4'h0, 1'b0, 1'b0);
        early = 1'b0;
        for (int i = 0; i < TO; i++) begin
            if (bus.timeout_o || bus.eng_abort_o) early = 1'b1;
            tick();
        end
        check_eq("wd_early", early, 1'b0);
        check_eq("wd_timeout", bus.timeout_o, 1'b1);
        check_eq("wd_abort", bus.eng_abort_o, 1'b1);
        tick();
        check_eq("wd_pulse", bus.timeout_o, 1'b0);
        check_eq("wd_no_done", bus.req_done_o, '0);
        tick();
        $display("job: req0 watchdog abort");

        // Done/abort collision, plus BUSY ready pass-through
        launch(1, 4'h8, 1'b1, 1'b1);
        bus.eng_ready_i = 1'b1; bus.eng_key_ready_i = 1'b1;
        bus.req_key_valid_i[1] = 1'b1; bus.req_key_i[W +: W] = 64'hC0FF_EE00_1234_5678;
        #1;
        check_eq("busy_ready", bus.req_ready_o, 2'b10);
        check_eq("busy_key_ready", bus.req_key_ready_o, 2'b10);
        check_eq("busy_key", bus.eng_key_o, 64'hC0FF_EE00_1234_5678);
        bus.eng_ready_i = 1'b0; bus.eng_key_ready_i = 1'b0; bus.req_key_valid_i = '0;
        bus.eng_hash_i = {8{64'h5555}};
        bus.eng_done_i = 1'b1;
        bus.req_abort_i = 2'b10;
        #1;
        check_eq("coll_abort", bus.eng_abort_o, 1'b0);
        tick();
        bus.eng_done_i = 1'b0; bus.req_abort_i = '0;
        #1;
        check_eq("coll_done", bus.req_done_o, 2'b10);
        check_eq("coll_hash", bus.hash_o, {8{64'h5555}});
        tick();
        $display("job: req1 done/abort collision");
        launch(1, 4'h8, 1'b0, 1'b0);
        finish_done(1, {8{64'h6666}});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
